// File: rtl/message_schedule_gen.sv
// SHA-256 message-schedule expander: takes one padded 512-bit block and
// streams W[0..63] over a valid/ready handshake using a 16-word sliding window.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a block; window holds last contents, no output
// STREAM | win[0] is W[t] on w_word; each transfer shifts in W[t+16]
module message_schedule_gen #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_word,
    output logic [5:0]   w_index,
    output logic         w_last
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] win_q [16];
    logic [5:0]  idx_q;
    logic        w_valid_q;
    logic        w_last_q;
    logic        blk_ready_q;

    logic [31:0] sig0_d;
    logic [31:0] sig1_d;
    logic [31:0] win_new_d;
    logic        xfer_d;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Expansion runs every cycle; the result is only used on a transfer.
    always_comb begin
        sig0_d    = small_sigma0(win_q[1]);
        sig1_d    = small_sigma1(win_q[14]);
        win_new_d = sig1_d + win_q[9] + sig0_d + win_q[0];
        xfer_d    = w_valid_q & w_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 6'd0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            blk_ready_q <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (blk_valid && blk_ready_q) begin
                        for (int i = 0; i < 16; i++) begin
                            win_q[i] <= blk_data[511 - 32*i -: 32];
                        end
                        idx_q       <= 6'd0;
                        w_valid_q   <= 1'b1;
                        w_last_q    <= 1'b0;
                        blk_ready_q <= 1'b0;
                        state_q     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (xfer_d) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q       <= 6'd0;
                            w_valid_q   <= 1'b0;
                            w_last_q    <= 1'b0;
                            blk_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                win_q[i] <= win_q[i+1];
                            end
                            win_q[15] <= win_new_d;
                            idx_q     <= idx_q + 6'd1;
                            w_last_q  <= (idx_q == LAST_IDX - 6'd1);
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    w_valid_q   <= 1'b0;
                    w_last_q    <= 1'b0;
                    blk_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign w_word    = win_q[0];
    assign w_index   = idx_q;
    assign w_last    = w_last_q;

endmodule

// File: tb/tb_message_schedule_gen.sv
// Directed bench for message_schedule_gen: abc block, backpressure,
// back-to-back blocks, ignored blk_valid, mid-stream reset and 2^32 wrap.
module tb_message_schedule_gen;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_word;
    logic [5:0]   w_index;
    logic         w_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [64];
    logic [31:0] got [64];

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_FF  = {512{1'b1}};
    localparam logic [511:0] BLK_ODD = {16{32'hA5C3_1E07}};

    message_schedule_gen #(.NUM_ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_word    (w_word),
        .w_index   (w_index),
        .w_last    (w_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule built as the flat 64-entry recurrence.
    task automatic build_model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) mdl[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            mdl[i] = (ror(mdl[i-2], 17) ^ ror(mdl[i-2], 19) ^ (mdl[i-2] >> 10))
                   + mdl[i-7]
                   + (ror(mdl[i-15], 7) ^ ror(mdl[i-15], 18) ^ (mdl[i-15] >> 3))
                   + mdl[i-16];
        end
    endtask

    task automatic send_block(input logic [511:0] b);
        @(negedge clk);
        chk("blk_ready_before_accept", 32'(blk_ready), 32'd1);
        blk_valid = 1'b1;
        blk_data  = b;
    endtask

    // Drives w_ready and consumes one 64-word stream, checking every sampled cycle.
    task automatic run_stream(input bit rnd, input bit hold_next,
                              input logic [511:0] next_blk, input int pulse_t);
        int          cnt = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw = 32'd0;
        logic [5:0]  pi = 6'd0;
        while (cnt < 64 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            chk("w_valid_held", 32'(w_valid), 32'd1);
            chk("blk_ready_low", 32'(blk_ready), 32'd0);
            if (w_valid) begin
                chk("w_index", 32'(w_index), 32'(cnt));
                chk("w_word", w_word, mdl[cnt]);
                chk("w_last", 32'(w_last), 32'(cnt == 63));
                if (stalled) begin
                    chk("stall_word", w_word, pw);
                    chk("stall_index", 32'(w_index), 32'(pi));
                end
                got[cnt] = w_word;
            end
            if (hold_next) begin
                blk_valid = 1'b1;
                blk_data  = next_blk;
            end else if (w_valid && pulse_t == cnt) begin
                blk_valid = 1'b1;
                blk_data  = BLK_ODD;
            end else begin
                blk_valid = 1'b0;
            end
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid && w_ready) begin
                cnt++;
                stalled = 1'b0;
            end else begin
                stalled = w_valid;
                pw      = w_word;
                pi      = w_index;
            end
        end
        chk("transfers", 32'(cnt), 32'd64);
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_w_last"}, 32'(w_last), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_blk_ready", 32'(blk_ready), 32'd1);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_index", 32'(w_index), 32'd0);
        chk("rst_w_last", 32'(w_last), 32'd0);
        chk("rst_w_word", w_word, 32'd0);
        rst_n = 1'b1;

        // abc block, w_ready held high
        build_model(BLK_ABC);
        send_block(BLK_ABC);
        run_stream(1'b0, 1'b0, '0, -1);
        chk("abc_w0", got[0], 32'h61626380);
        chk("abc_w14", got[14], 32'h00000000);
        chk("abc_w15", got[15], 32'h00000018);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);
        chk("abc_w18", got[18], 32'h7DA86405);
        check_idle_after("abc_done");

        // same block under pseudo-random backpressure
        send_block(BLK_ABC);
        run_stream(1'b1, 1'b0, '0, -1);
        chk("bp_w18", got[18], 32'h7DA86405);
        check_idle_after("bp_done");

        // back-to-back: valid held, FF block queued behind abc
        send_block(BLK_ABC);
        run_stream(1'b0, 1'b1, BLK_FF, -1);
        check_idle_after("b2b_gap");
        build_model(BLK_FF);
        run_stream(1'b0, 1'b0, '0, -1);
        chk("ff_w0", got[0], 32'hFFFFFFFF);
        chk("ff_w15", got[15], 32'hFFFFFFFF);
        chk("ff_w16_wrap", got[16], 32'h203FFFFC);
        check_idle_after("ff_done");

        // blk_valid pulse at t = 10 must be ignored
        build_model(BLK_ABC);
        send_block(BLK_ABC);
        run_stream(1'b0, 1'b0, '0, 10);
        chk("ign_w17", got[17], 32'h000F0000);
        check_idle_after("ign_done");

        // asynchronous reset at t = 30
        send_block(BLK_ABC);
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                blk_valid = 1'b0;
                w_ready   = 1'b1;
                if (w_valid && w_index == 6'd30) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reach_t30", 32'(hit), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_w_valid", 32'(w_valid), 32'd0);
        chk("arst_w_index", 32'(w_index), 32'd0);
        chk("arst_w_last", 32'(w_last), 32'd0);
        chk("arst_w_word", w_word, 32'd0);
        chk("arst_blk_ready", 32'(blk_ready), 32'd1);
        w_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_valid", 32'(w_valid), 32'd0);
        build_model(BLK_FF);
        send_block(BLK_FF);
        run_stream(1'b0, 1'b0, '0, -1);
        chk("post_rst_w16", got[16], 32'h203FFFFC);
        check_idle_after("post_rst_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_schedule_gen.md
Name: message_schedule_gen

Overview:
- Sequential SHA-256 message-schedule expander; the producer side of the schedule that the compression rounds consume.
- Accepts one 512-bit padded message block and streams W[0..63] one 32-bit word per handshake into the round datapath.
- Uses a 16-word sliding window instead of a 64-entry flat array, so the compression side can run one round per cycle.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block. Only 64 is legal; the parameter exists for lint and bench visibility.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- blk_valid  input  1  message block on blk_data is valid.
- blk_ready  output  1  block can be accepted this cycle.
- blk_data  input  512  padded message block. Bits [511:480] are M[0] (first big-endian word); bits [31:0] are M[15].
- w_valid  output  1  w_word holds schedule word W[w_index].
- w_ready  input  1  round datapath consumes w_word this cycle.
- w_word  output  32  schedule word W[t].
- w_index  output  6  round index t, 0..63.
- w_last  output  1  high with w_valid when t = 63.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets the following:
  - state = IDLE, blk_ready = 1.
  - w_valid = 0, w_index = 0, w_last = 0, w_word = 0.
  - all window registers = 0.
- States:
  - IDLE: blk_ready = 1, w_valid = 0.
    - On blk_valid & blk_ready: load win[i] = M[i] for i = 0..15, set t = 0, go to STREAM.
  - STREAM: blk_ready = 0, w_valid = 1, w_word = win[0], w_index = t, w_last = (t == 63).
    - On w_valid & w_ready with t < 63: shift win[i] <= win[i+1] for i = 0..14, win[15] <= new, t <= t + 1.
    - On w_valid & w_ready with t = 63: go to IDLE, t <= 0.
    - If w_ready = 0: hold all state and outputs stable (AXI-style; w_word must not change while stalled).
- Expansion arithmetic, computed each cycle from the current window:
  - new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32 (carries out of bit 31 discarded).
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Pure combinational, one adder tree; no multicycle paths.
- Latency and throughput:
  - First word is visible the cycle after the block is accepted.
  - With w_ready held high, 64 consecutive words are emitted in 64 cycles.
  - blk_ready returns high the cycle after the W[63] transfer, so one block occupies 65 cycles minimum.
- Words W[48..63] are emitted after their producing expansions. Expansions done during t = 48..63 compute W[64..79], which are discarded; no special-casing is required.
- blk_valid during STREAM is ignored; the block stays pending upstream because blk_ready = 0.
- rst_n asserted mid-stream aborts immediately: all outputs return to reset values and no partial output remains. On release the block waits in IDLE for a fresh block.
- w_valid never drops between t = 0 and t = 63 without a reset.
- blk_data is sampled only at the accepting edge; changes afterwards have no effect.

Test Plan:
- Single block "abc", w_ready held 1. Stimulus: blk_data = 0x61626380, then 13 zero words, then 0x00000000 0x00000018. Required response:
  - W[0] = 0x61626380, W[1..14] = 0, W[15] = 0x00000018.
  - W[16] = 0x61626380, W[17] = 0x000F0000, W[18] = 0x7DA86405.
  - W[0..63] match the software model; w_last only at t = 63.
  - blk_ready high the cycle after t = 63.
- Backpressure: same block, w_ready toggled by a pseudo-random pattern (about 50% duty).
  - Identical W sequence.
  - w_word and w_index stable during every stall cycle.
  - Total transfers = 64.
- Back-to-back blocks: blk_valid held high with the "abc" block, then an all-0xFFFFFFFF block.
  - Second block accepted exactly one cycle after the first w_last transfer.
  - Its W[0..15] are all 0xFFFFFFFF; the remaining words match the model.
- Ignored input: blk_valid pulsed at t = 10 with a different block.
  - No effect on the stream.
  - blk_ready stays 0 until the stream completes.
- Reset mid-operation: assert rst_n = 0 at t = 30, asynchronously between clock edges.
  - w_valid, w_index and w_last fall immediately.
  - After release, blk_ready = 1, and a new block streams correctly from W[0].
- Arithmetic wrap: all-0xFFFFFFFF block.
  - W[16] equals the model's mod 2^32 sum, with no carry propagated into later words.
